// File: rtl/tdc_stream_sequencer.sv
// ============================================================================
//  Module : tdc_stream_sequencer
//  Collects one TDC timestamp per pixel per acquisition and streams them to
//  the histogram builder; optional test pattern via STREAM_TEST_PATTERN_EN.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tdc_stream_sequencer #(
    parameter int NP            = 10,
    parameter int PIXEL_NUM     = 6,
    parameter int ACQ_NUM       = 2,
    parameter int WINDOW_CYCLES = 64
) (
    input  logic                                           clk,
    input  logic                                           res,
    input  logic                                           acqStart,
    input  logic [PIXEL_NUM-1:0]                           tdcValid,
    input  logic [NP*PIXEL_NUM-1:0]                        tdcData,
    input  logic                                           testMode,
    output logic                                           wrEn,
    output logic [NP-1:0]                                  data,
    output logic [((ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1)-1:0] acqIdx,
    output logic                                           busy,
    output logic                                           frameDone,
    output logic                                           overflow
);

    localparam int c_acqW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int c_pixW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int c_winW = $clog2(WINDOW_CYCLES);

    localparam logic [NP-1:0]     c_noHit   = {NP{1'b1}};
    localparam logic [NP-1:0]     c_satHit  = c_noHit - 1'b1;
    localparam logic [c_winW-1:0] c_winLoad = c_winW'(WINDOW_CYCLES - 1);
    localparam logic [c_pixW-1:0] c_lastPix = c_pixW'(PIXEL_NUM - 1);
    localparam logic [c_acqW-1:0] c_lastAcq = c_acqW'(ACQ_NUM - 1);

    localparam logic [1:0] c_stIdle    = 2'd0;
    localparam logic [1:0] c_stCollect = 2'd1;
    localparam logic [1:0] c_stEmit    = 2'd2;
    localparam logic [1:0] c_stDone    = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [c_winW-1:0]    r_winCnt;
    logic [c_pixW-1:0]    r_pixIdx;
    logic [c_acqW-1:0]    r_acqIdx;
    logic [PIXEL_NUM-1:0] r_valid;
    logic [NP-1:0]        r_ts [PIXEL_NUM];
    logic                 r_wrEn;
    logic [NP-1:0]        r_data;
    logic                 r_overflow;

    logic [PIXEL_NUM-1:0] w_hit;
    logic [PIXEL_NUM-1:0] w_nextValid;
    logic [NP-1:0]        w_nextTs [PIXEL_NUM];
    logic [c_pixW-1:0]    w_sel;
    logic [NP-1:0]        w_pixWord;
    logic [NP-1:0]        w_word;
    logic                 w_wrEnNext;
    logic [NP-1:0]        w_dataNext;

    // A hit on the last window cycle must reach word 0 in the very next
    // cycle, so the word mux reads the post-capture view of the registers.
    generate
        for (genvar p = 0; p < PIXEL_NUM; p++) begin : g_pix
            assign w_hit[p]       = (r_state == c_stCollect) && tdcValid[p] && !r_valid[p];
            assign w_nextValid[p] = (r_state == c_stIdle) ? 1'b0 : (r_valid[p] | w_hit[p]);
            assign w_nextTs[p]    = w_hit[p] ? tdcData[p*NP +: NP] : r_ts[p];
        end
    endgenerate

    assign w_pixWord = !w_nextValid[w_sel]         ? c_noHit  :
                       (w_nextTs[w_sel] == c_noHit) ? c_satHit : w_nextTs[w_sel];

`ifdef STREAM_TEST_PATTERN_EN
    logic          r_testMode;
    logic [NP-1:0] r_lfsr;
    logic [NP-1:0] w_lfsrNext;

    assign w_lfsrNext = {r_lfsr[NP-2:0], r_lfsr[NP-1] ^ r_lfsr[NP-4]};
    assign w_word     = r_testMode ? r_lfsr : w_pixWord;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_testMode <= 1'b0;
            r_lfsr     <= {{(NP-1){1'b0}}, 1'b1};
        end else begin
            if (r_state == c_stIdle && acqStart) begin
                r_testMode <= testMode;
            end
            if (w_wrEnNext && r_testMode) begin
                r_lfsr <= w_lfsrNext;
            end
        end
    end
`else
    logic w_unusedTestMode;

    assign w_unusedTestMode = testMode;
    assign w_word           = w_pixWord;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle:    if (acqStart) w_nextState = c_stCollect;
            c_stCollect: if (r_winCnt == '0) w_nextState = c_stEmit;
            c_stEmit: begin
                if (r_pixIdx == c_lastPix) begin
                    w_nextState = (r_acqIdx == c_lastAcq) ? c_stDone : c_stIdle;
                end
            end
            default:     w_nextState = c_stIdle;
        endcase
    end

    always_comb begin
        busy       = (r_state == c_stCollect) || (r_state == c_stEmit);
        frameDone  = (r_state == c_stDone);
        w_wrEnNext = 1'b0;
        w_sel      = '0;
        case (r_state)
            c_stCollect: w_wrEnNext = (r_winCnt == '0);
            c_stEmit: begin
                if (r_pixIdx != c_lastPix) begin
                    w_wrEnNext = 1'b1;
                    w_sel      = r_pixIdx + 1'b1;
                end
            end
            default: w_wrEnNext = 1'b0;
        endcase
        w_dataNext = w_wrEnNext ? w_word : '0;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_winCnt   <= '0;
            r_pixIdx   <= '0;
            r_acqIdx   <= '0;
            r_valid    <= '0;
            r_wrEn     <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
            for (int p = 0; p < PIXEL_NUM; p++) begin
                r_ts[p] <= '0;
            end
        end else begin
            r_valid <= w_nextValid;
            for (int p = 0; p < PIXEL_NUM; p++) begin
                r_ts[p] <= w_nextTs[p];
            end
            r_wrEn <= w_wrEnNext;
            r_data <= w_dataNext;
            r_winCnt <= (r_state == c_stIdle) ? c_winLoad : (r_winCnt - 1'b1);
            if (r_state == c_stEmit && r_pixIdx != c_lastPix) begin
                r_pixIdx <= r_pixIdx + 1'b1;
            end else begin
                r_pixIdx <= '0;
            end
            if (r_state == c_stEmit && r_pixIdx == c_lastPix && r_acqIdx != c_lastAcq) begin
                r_acqIdx <= r_acqIdx + 1'b1;
            end else if (r_state == c_stDone) begin
                r_acqIdx <= '0;
            end
            if (acqStart && r_state != c_stIdle) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wrEn     = r_wrEn;
    assign data     = r_data;
    assign acqIdx   = r_acqIdx;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_tdc_stream_sequencer.sv
// ============================================================================
//  Module : tb_tdc_stream_sequencer
//  Directed bench: streams, frame completion, window edges, overflow, reset.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tdc_stream_sequencer;

    logic        clk      = 1'b0;
    logic        res      = 1'b1;
    logic        acqStart = 1'b0;
    logic        testMode = 1'b0;
    logic [5:0]  tdcValid = '0;
    logic [59:0] tdcData  = '0;
    logic        wrEn;
    logic [9:0]  data;
    logic [0:0]  acqIdx;
    logic        busy;
    logic        frameDone;
    logic        overflow;

    int vecCnt = 0;
    int errCnt = 0;

    always #5 clk = ~clk;

    tdc_stream_sequencer #(
        .NP(10), .PIXEL_NUM(6), .ACQ_NUM(2), .WINDOW_CYCLES(64)
    ) dut (
        .clk(clk), .res(res), .acqStart(acqStart), .tdcValid(tdcValid),
        .tdcData(tdcData), .testMode(testMode), .wrEn(wrEn), .data(data),
        .acqIdx(acqIdx), .busy(busy), .frameDone(frameDone), .overflow(overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] px(input int p, input int v);
        logic [59:0] t;
        t = 60'(v);
        return t << (p * 10);
    endfunction

    function automatic logic [59:0] w6(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        return {10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    // Edge 0 samples acqStart; edges 1..64 are the collection window.
    task automatic acquire(input int eA, input logic [5:0] mA, input logic [59:0] dA,
                           input int eB, input logic [5:0] mB, input logic [59:0] dB);
        for (int e = 0; e <= 64; e++) begin
            acqStart = (e == 0);
            tdcValid = (e == eA) ? mA : ((e == eB) ? mB : 6'd0);
            tdcData  = (e == eA) ? dA : ((e == eB) ? dB : 60'd0);
            step();
            if (e == 0) chk("busyCollect", 32'(busy), 32'd1);
        end
        acqStart = 1'b0;
        tdcValid = '0;
        tdcData  = '0;
    endtask

    task automatic emit(input string tag, input logic [59:0] exp, input int nWords,
                        input int pulseAt, input logic expIdx);
        logic [9:0] w;
        for (int k = 0; k < nWords; k++) begin
            w = exp[k*10 +: 10];
            chk($sformatf("%s.wrEn%0d", tag, k), 32'(wrEn), 32'd1);
            chk($sformatf("%s.data%0d", tag, k), 32'(data), 32'(w));
            chk($sformatf("%s.idx%0d", tag, k), 32'(acqIdx), 32'(expIdx));
            if (k == pulseAt) acqStart = 1'b1;
            step();
            acqStart = 1'b0;
        end
    endtask

    initial begin
        logic sawWr;

        #1;
        chk("rst.wrEn", 32'(wrEn), 32'd0);
        chk("rst.data", 32'(data), 32'd0);
        chk("rst.acqIdx", 32'(acqIdx), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.frameDone", 32'(frameDone), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        step();
        step();
        res = 1'b0;
        step();

        // Basic stream, acquisition 0
        acquire(3, 6'b000001, px(0, 108), 10, 6'b000110, px(1, 511) | px(2, 1022));
        emit("A", w6(108, 511, 1022, 1023, 1023, 1023), 6, -1, 1'b0);
        chk("A.endWrEn", 32'(wrEn), 32'd0);
        chk("A.endData", 32'(data), 32'd0);
        chk("A.noFrame", 32'(frameDone), 32'd0);
        chk("A.idxNext", 32'(acqIdx), 32'd1);
        chk("A.idle", 32'(busy), 32'd0);
        step();

        // First hit wins, 1023 saturates; last acquisition of frame
        acquire(5, 6'b000001, px(0, 300), 20, 6'b000011, px(0, 50) | px(1, 1023));
        emit("B", w6(300, 1022, 1023, 1023, 1023, 1023), 6, -1, 1'b1);
        chk("B.frameDone", 32'(frameDone), 32'd1);
        chk("B.busy", 32'(busy), 32'd0);
        step();
        chk("B.framePulse", 32'(frameDone), 32'd0);
        chk("B.idxClr", 32'(acqIdx), 32'd0);

        // Hit on acqStart cycle dropped, hits on last window cycle kept
        acquire(0, 6'b001000, px(3, 77), 64, 6'b010001, px(0, 200) | px(4, 555));
        emit("C", w6(200, 1023, 1023, 1023, 555, 1023), 6, -1, 1'b0);
        chk("C.noOverflow", 32'(overflow), 32'd0);
        step();

        // acqStart during EMIT: overflow, stream intact
        acquire(30, 6'b000100, px(2, 42), -1, 6'd0, 60'd0);
        emit("D", w6(1023, 1023, 42, 1023, 1023, 1023), 6, 2, 1'b1);
        chk("D.overflow", 32'(overflow), 32'd1);
        chk("D.frameDone", 32'(frameDone), 32'd1);
        step();
        chk("D.notStarted", 32'(busy), 32'd0);

        acquire(40, 6'b100000, px(5, 1000), -1, 6'd0, 60'd0);
        emit("F", w6(1023, 1023, 1023, 1023, 1023, 1000), 6, -1, 1'b0);
        step();
        chk("F.sticky", 32'(overflow), 32'd1);

        // Reset mid-EMIT aborts the stream
        acquire(2, 6'b000001, px(0, 5), -1, 6'd0, 60'd0);
        emit("E", w6(5, 1023, 1023, 1023, 1023, 1023), 2, -1, 1'b1);
        res = 1'b1;
        #1;
        chk("E.rstWrEn", 32'(wrEn), 32'd0);
        chk("E.rstData", 32'(data), 32'd0);
        chk("E.rstBusy", 32'(busy), 32'd0);
        chk("E.rstOverflow", 32'(overflow), 32'd0);
        chk("E.rstIdx", 32'(acqIdx), 32'd0);
        chk("E.rstFrame", 32'(frameDone), 32'd0);
        step();
        res = 1'b0;
        sawWr = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            sawWr = sawWr | wrEn | busy;
        end
        chk("E.noResume", 32'(sawWr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

`default_nettype wire
